// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between execute stage and the HI/LO sequencer.
// master = execute stage, slave = hilo_muldiv_ctrl.
interface hilo_muldiv_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        annul;
    logic        stall_request;
    logic        busy;
    logic        hi_write_enable;
    logic [31:0] hi_write_data;
    logic        lo_write_enable;
    logic [31:0] lo_write_data;

    modport master (
        output op_valid, op_code, operand_a, operand_b, annul,
        input  stall_request, busy,
        input  hi_write_enable, hi_write_data,
        input  lo_write_enable, lo_write_data
    );

    modport slave (
        input  op_valid, op_code, operand_a, operand_b, annul,
        output stall_request, busy,
        output hi_write_enable, hi_write_data,
        output lo_write_enable, lo_write_data
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: 1-cycle MULT/MULTU, MTHI/MTLO, 32-step restoring DIV/DIVU.
// Optional macro DIV_ZERO_FAST_EN: divide by zero skips the iteration phase.
module hilo_muldiv_ctrl #(
    parameter int DIV_STEPS = 32
) (
    input logic          clock,
    input logic          reset,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(DIV_STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rem;
    logic [31:0]   r_quo;
    logic [31:0]   r_dvsr;
    logic [31:0]   r_a_raw;
    logic          r_bzero;
    logic          r_qneg;
    logic          r_rneg;
    logic          r_hi_we;
    logic          r_lo_we;
    logic [31:0]   r_hi_wd;
    logic [31:0]   r_lo_wd;

    logic w_accept;
    logic w_is_mult;
    logic w_is_multu;
    logic w_is_div;
    logic w_is_divu;
    logic w_is_mthi;
    logic w_is_mtlo;
    logic w_div_req;
    logic w_b_zero;
    logic w_fast_zero;
    logic w_stall;
    logic w_busy;
    logic w_kill;
    logic w_fit;
    logic w_div_fin;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [31:0] w_sub;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_lo_div;
    logic [31:0] w_hi_div;

    assign w_is_mult  = bus.op_code == 3'd0;
    assign w_is_multu = bus.op_code == 3'd1;
    assign w_is_div   = bus.op_code == 3'd2;
    assign w_is_divu  = bus.op_code == 3'd3;
    assign w_is_mthi  = bus.op_code == 3'd4;
    assign w_is_mtlo  = bus.op_code == 3'd5;
    assign w_div_req  = w_is_div | w_is_divu;
    assign w_b_zero   = bus.operand_b == 32'd0;
    assign w_accept   = (r_state == IDLE) & bus.op_valid & ~bus.annul;

`ifdef DIV_ZERO_FAST_EN
    assign w_fast_zero = w_b_zero;
`else
    assign w_fast_zero = 1'b0;
`endif

    // Sign-extended 64-bit operands make the modular product the signed one.
    assign w_prod_s = {{32{bus.operand_a[31]}}, bus.operand_a}
                    * {{32{bus.operand_b[31]}}, bus.operand_b};
    assign w_prod_u = {32'd0, bus.operand_a} * {32'd0, bus.operand_b};

    assign w_a_mag = (w_is_div & bus.operand_a[31]) ?
                     (~bus.operand_a + 32'd1) : bus.operand_a;
    assign w_b_mag = (w_is_div & bus.operand_b[31]) ?
                     (~bus.operand_b + 32'd1) : bus.operand_b;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_fit     = w_shift >= {1'b0, r_dvsr};
    assign w_sub     = w_shift[31:0] - r_dvsr;
    assign w_rem_nxt = w_fit ? w_sub : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_fit};

    // A zero divisor yields all-ones quotient and the raw dividend as remainder.
    assign w_lo_div = r_bzero ? 32'hFFFF_FFFF :
                      r_qneg  ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
    assign w_hi_div = r_bzero ? r_a_raw :
                      r_rneg  ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

    assign w_div_fin = (r_state == DIV_RUN) & ~bus.annul & (r_cnt == LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state, stall and busy decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_busy      = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_accept & w_div_req) begin
                    w_stall     = 1'b1;
                    w_state_nxt = w_fast_zero ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                w_stall = 1'b1;
                if (bus.annul)          w_state_nxt = IDLE;
                else if (r_cnt == LAST) w_state_nxt = DIV_DONE;
            end
            DIV_DONE: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Iteration counter: counts steps while the divider stays in DIV_RUN.
    always_ff @(posedge clock) begin
        if (reset)
            r_cnt <= '0;
        else if (r_state == DIV_RUN && w_state_nxt == DIV_RUN)
            r_cnt <= r_cnt + CW'(1);
        else
            r_cnt <= '0;
    end

    // Divider datapath: latch magnitudes and signs, then iterate.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_a_raw <= '0;
            r_bzero <= 1'b0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else if (w_accept & w_div_req) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvsr  <= w_b_mag;
            r_a_raw <= bus.operand_a;
            r_bzero <= w_b_zero;
            r_qneg  <= w_is_div & (bus.operand_a[31] ^ bus.operand_b[31]);
            r_rneg  <= w_is_div & bus.operand_a[31];
        end else if (r_state == DIV_RUN) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

    // Registered one-cycle HI/LO strobes; everything clears the cycle after.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi_we <= 1'b0;
            r_lo_we <= 1'b0;
            r_hi_wd <= '0;
            r_lo_wd <= '0;
        end else begin
            r_hi_we <= 1'b0;
            r_lo_we <= 1'b0;
            r_hi_wd <= '0;
            r_lo_wd <= '0;
            if (w_accept) begin
                unique case (1'b1)
                    w_is_mult: begin
                        r_hi_we <= 1'b1;
                        r_lo_we <= 1'b1;
                        r_hi_wd <= w_prod_s[63:32];
                        r_lo_wd <= w_prod_s[31:0];
                    end
                    w_is_multu: begin
                        r_hi_we <= 1'b1;
                        r_lo_we <= 1'b1;
                        r_hi_wd <= w_prod_u[63:32];
                        r_lo_wd <= w_prod_u[31:0];
                    end
                    w_is_mthi: begin
                        r_hi_we <= 1'b1;
                        r_hi_wd <= bus.operand_a;
                    end
                    w_is_mtlo: begin
                        r_lo_we <= 1'b1;
                        r_lo_wd <= bus.operand_a;
                    end
                    w_div_req & w_fast_zero: begin
                        r_hi_we <= 1'b1;
                        r_lo_we <= 1'b1;
                        r_hi_wd <= bus.operand_a;
                        r_lo_wd <= 32'hFFFF_FFFF;
                    end
                    default: ;
                endcase
            end
            if (w_div_fin) begin
                r_hi_we <= 1'b1;
                r_lo_we <= 1'b1;
                r_hi_wd <= w_hi_div;
                r_lo_wd <= w_lo_div;
            end
        end
    end

    // A flush landing on the divide result cycle suppresses that write.
    assign w_kill = (r_state == DIV_DONE) & bus.annul;

    assign bus.stall_request   = w_stall;
    assign bus.busy            = w_busy;
    assign bus.hi_write_enable = r_hi_we & ~w_kill;
    assign bus.lo_write_enable = r_lo_we & ~w_kill;
    assign bus.hi_write_data   = r_hi_wd;
    assign bus.lo_write_data   = r_lo_wd;
endmodule
